// File: rtl/secret_accum_sched_pkg.sv
// secret_sched_pkg: shared types, defaults and round-robin pick for the accumulator scheduler
package secret_sched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int DEF_DW      = 32;
    localparam int DEF_ACC_LAT = 1;

    // First set bit of valid at or after ptr, wrapping at n; ptr when none is set
    function automatic int rr_pick(input logic [7:0] valid, input int ptr, input int n);
        int j;
        rr_pick = ptr;
        for (int k = n - 1; k >= 0; k--) begin
            j = (ptr + k) % n;
            if (valid[j[2:0]]) rr_pick = j;
        end
    endfunction

endpackage

// File: rtl/secret_accum_sched_if.sv
// secret_accum_sched_if: requester-side request bus and tagged response channel
interface secret_accum_sched_if #(
    parameter int NREQ = 2,
    parameter int DW   = 32
);
    localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_bypass;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid, req_data, req_bypass, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_bypass, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/secret_accum_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner search starting at a pointer
module rr_arbiter
    import secret_sched_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = NREQ > 1 ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);

    logic [7:0]     w_valid;
    logic [IDW-1:0] w_idx;

    assign w_valid = 8'(i_valid);
    assign w_idx   = IDW'(rr_pick(w_valid, int'(i_ptr), NREQ));
    assign o_idx   = w_idx;
    assign o_grant = (|i_valid) ? (NREQ'(1) << w_idx) : '0;

endmodule

// File: rtl/secret_accum_sched.sv
// secret_accum_sched: round-robin time-sharing of one secret accumulator among NREQ requesters
module secret_accum_sched
    import secret_sched_pkg::*;
#(
    parameter  int NREQ    = 2,
    parameter  int DW      = DEF_DW,
    parameter  int ACC_LAT = DEF_ACC_LAT,
    localparam int IDW     = NREQ > 1 ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    secret_accum_sched_if.slave  bus,
    output logic [DW-1:0]        accum_in,
    output logic                 accum_bypass,
    input  logic [DW-1:0]        accum_out,
    input  logic [DW-1:0]        accum_bypass_out,
    output logic                 busy
);

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [2:0]      r_cnt;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_data;
    logic [DW-1:0]   r_accum_in;
    logic            r_accum_byp;
    logic            r_busy;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_valid (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Ready is offered only while idle, and never while reset is held
    assign bus.req_ready = (r_state == IDLE && !rst) ? w_grant : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_data  = r_rsp_data;
    assign accum_in      = r_accum_in;
    assign accum_bypass  = r_accum_byp;
    assign busy          = r_busy;

    // Transaction sequencer: accept, drive the accumulator for one cycle, wait out its latency, answer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_accum_in  <= '0;
            r_accum_byp <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (|bus.req_valid) begin
                    r_id        <= w_idx;
                    r_accum_in  <= bus.req_data[int'(w_idx)*DW +: DW];
                    r_accum_byp <= bus.req_bypass[w_idx];
                    r_busy      <= 1'b1;
                    r_state     <= ISSUE;
                end
                ISSUE: begin
                    r_accum_in  <= '0;
                    r_accum_byp <= 1'b0;
                    if (r_accum_byp) begin
                        r_rsp_data  <= accum_bypass_out;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt   <= 3'(ACC_LAT - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: if (r_cnt == '0) begin
                    r_rsp_data  <= accum_out;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end else begin
                    r_cnt <= r_cnt - 3'd1;
                end
                RESP: if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_ptr       <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secret_accum_sched.sv
// tb_secret_accum_sched: ACC_LAT=1 and ACC_LAT=3 schedulers against a transaction-level model
module tb_secret_accum_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [63:0] req_data;
    logic [1:0]  req_bypass;
    logic        rsp_ready;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] ain  [2];
    logic        ab   [2];
    logic [31:0] abo  [2];
    logic        bsy  [2];
    logic [1:0]  d_ready [2];
    logic        d_rv [2];
    logic        d_id [2];
    logic [31:0] d_rd [2];
    logic [31:0] acc  [2] = '{32'h0000_1000, 32'hFFFF_FFF0};
    int          lat  [2] = '{1, 3};

    always #5 clk = ~clk;

    secret_accum_sched_if #(.NREQ(2), .DW(32)) if1 ();
    secret_accum_sched_if #(.NREQ(2), .DW(32)) if3 ();

    assign if1.req_valid = req_valid;  assign if3.req_valid = req_valid;
    assign if1.req_data = req_data;    assign if3.req_data = req_data;
    assign if1.req_bypass = req_bypass; assign if3.req_bypass = req_bypass;
    assign if1.rsp_ready = rsp_ready;  assign if3.rsp_ready = rsp_ready;

    assign d_ready[0] = if1.req_ready; assign d_ready[1] = if3.req_ready;
    assign d_rv[0] = if1.rsp_valid;    assign d_rv[1] = if3.rsp_valid;
    assign d_id[0] = if1.rsp_id;       assign d_id[1] = if3.rsp_id;
    assign d_rd[0] = if1.rsp_data;     assign d_rd[1] = if3.rsp_data;

    secret_accum_sched #(.NREQ(2), .DW(32), .ACC_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .accum_in(ain[0]), .accum_bypass(ab[0]),
        .accum_out(acc[0]), .accum_bypass_out(abo[0]), .busy(bsy[0])
    );

    secret_accum_sched #(.NREQ(2), .DW(32), .ACC_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(if3), .accum_in(ain[1]), .accum_bypass(ab[1]),
        .accum_out(acc[1]), .accum_bypass_out(abo[1]), .busy(bsy[1])
    );

    // Stand-in for the secret core: free-running acc += in + 7, combinational bypass mux
    always @(posedge clk) for (int u = 0; u < 2; u++) acc[u] <= acc[u] + ain[u] + 32'd7;
    assign abo[0] = ab[0] ? ain[0] : acc[0];
    assign abo[1] = ab[1] ? ain[1] : acc[1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int win(input logic [1:0] v, input int p);
        for (int k = 0; k < 2; k++) if (v[(p + k) % 2]) return (p + k) % 2;
        return 0;
    endfunction

    // Model: cycles since handshake (-1 idle), transaction fields, pointer, expected result
    int          m_k   [2] = '{-1, -1};
    int          m_id  [2];
    logic [31:0] m_dat [2];
    logic        m_byp [2];
    int          m_ptr [2] = '{0, 0};
    logic [31:0] m_val [2];

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                chk($sformatf("u%0d.rst.rsp_valid", u), d_rv[u], 0);
                chk($sformatf("u%0d.rst.busy", u), bsy[u], 0);
                chk($sformatf("u%0d.rst.req_ready", u), d_ready[u], 0);
                chk($sformatf("u%0d.rst.accum_in", u), ain[u], 0);
                m_k[u] = -1;
                m_ptr[u] = 0;
            end else begin
                int  rs;
                int  w;
                logic ev;
                rs = m_byp[u] ? 2 : 2 + lat[u];
                ev = m_k[u] >= rs;
                w  = win(req_valid, m_ptr[u]);
                chk($sformatf("u%0d.req_ready", u), d_ready[u],
                    (m_k[u] < 0 && req_valid != 0) ? 2'(1 << w) : 2'b00);
                chk($sformatf("u%0d.busy", u), bsy[u], m_k[u] >= 1);
                chk($sformatf("u%0d.rsp_valid", u), d_rv[u], ev);
                chk($sformatf("u%0d.accum_in", u), ain[u], m_k[u] == 1 ? m_dat[u] : 32'd0);
                chk($sformatf("u%0d.accum_bypass", u), ab[u], m_k[u] == 1 && m_byp[u]);
                if (ev) begin
                    chk($sformatf("u%0d.rsp_id", u), d_id[u], m_id[u]);
                    chk($sformatf("u%0d.rsp_data", u), d_rd[u], m_val[u]);
                end
                if (m_k[u] < 0) begin
                    if (req_valid != 0) begin
                        m_k[u]   = 1;
                        m_id[u]  = w;
                        m_dat[u] = req_data[w*32 +: 32];
                        m_byp[u] = req_bypass[w];
                    end
                end else if (ev) begin
                    if (rsp_ready) begin
                        m_k[u]   = -1;
                        m_ptr[u] = (m_id[u] + 1) % 2;
                    end
                end else begin
                    if (m_k[u] == 1) m_val[u] = m_byp[u] ? m_dat[u] : acc[u] + m_dat[u] + 32'(7 * lat[u]);
                    m_k[u]++;
                end
            end
        end
    end

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bsy[0] || bsy[1] || d_rv[0] || d_rv[1]) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle.timeout", n < 30, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] sd;
        logic        sid;
        int          g_t [4];
        int          g_i [4];
        int          ng;
        rst = 1'b1; req_valid = '0; req_data = '0; req_bypass = '0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("reset.rsp_id", d_id[0], 0);
        chk("reset.rsp_data", d_rd[0], 0);
        chk("reset.accum_bypass", ab[0], 0);
        drive(); rst = 1'b0;
        req_valid = 2'b01; req_data = 64'h0000_0000_0000_1234; req_bypass = 2'b01;
        @(negedge clk); chk("byp.ready", d_ready[0], 2'b01);
        drive(); req_valid = '0;
        @(negedge clk); chk("byp.accum_bypass_c1", ab[0], 1);
        @(negedge clk);
        chk("byp.rsp_valid_c2", d_rv[0], 1);
        chk("byp.rsp_id", d_id[0], 0);
        chk("byp.rsp_data", d_rd[0], 32'h0000_1234);
        chk("byp.accum_bypass_c2", ab[0], 0);
        wait_idle();
        drive(); req_valid = 2'b10; req_data = {32'd5, 32'hDEAD_BEEF}; req_bypass = 2'b00;
        @(negedge clk); chk("acc.ready", d_ready[0], 2'b10);
        drive(); req_valid = '0;
        @(negedge clk); a = acc[0];
        @(negedge clk); chk("acc.early", d_rv[0], 0);
        @(negedge clk);
        chk("acc.rsp_valid_c3", d_rv[0], 1);
        chk("acc.rsp_id", d_id[0], 1);
        chk("acc.rsp_data", d_rd[0], a + 32'd12);
        wait_idle();
        drive(); req_valid = 2'b01; req_data = {32'd0, 32'hFFFF_FFFF}; req_bypass = 2'b00;
        @(negedge clk); chk("lat3.ready", d_ready[1], 2'b01);
        drive(); req_valid = '0;
        @(negedge clk); a = acc[1];
        repeat (3) @(negedge clk);
        chk("lat3.early_c4", d_rv[1], 0);
        @(negedge clk);
        chk("lat3.rsp_valid_c5", d_rv[1], 1);
        chk("lat3.rsp_data", d_rd[1], a + 32'd20);
        wait_idle();
        drive(); rst = 1'b1;
        @(negedge clk);
        drive(); rst = 1'b0; req_valid = 2'b11; req_bypass = 2'b00; req_data = {$urandom, $urandom};
        ng = 0;
        for (int t = 0; t < 24 && ng < 4; t++) begin
            @(negedge clk);
            if (d_ready[0] != 0) begin
                g_t[ng] = t;
                g_i[ng] = d_ready[0][1] ? 1 : 0;
                ng++;
            end
        end
        chk("rr.count", ng, 4);
        for (int k = 0; k < ng; k++) chk($sformatf("rr.idx%0d", k), g_i[k], k % 2);
        for (int k = 1; k < ng; k++) chk($sformatf("rr.gap%0d", k), g_t[k] - g_t[k-1], 4);
        drive(); req_valid = '0;
        wait_idle();
        drive(); rsp_ready = 1'b0; req_valid = 2'b01; req_data = {$urandom, $urandom};
        drive(); req_valid = 2'b11;
        ng = 0;
        while (!d_rv[0] && ng < 10) begin @(negedge clk); ng++; end
        chk("bp.rsp_seen", d_rv[0], 1);
        sid = d_id[0]; sd = d_rd[0];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp.rsp_valid", d_rv[0], 1);
            chk("bp.rsp_id", d_id[0], sid);
            chk("bp.rsp_data", d_rd[0], sd);
            chk("bp.req_ready", d_ready[0], 0);
            chk("bp.busy", bsy[0], 1);
        end
        drive(); rsp_ready = 1'b1;
        @(negedge clk); chk("bp.last_valid", d_rv[0], 1);
        @(negedge clk);
        chk("bp.done_valid", d_rv[0], 0);
        chk("bp.done_busy", bsy[0], 0);
        drive(); req_valid = '0;
        wait_idle();
        drive(); req_valid = 2'b01; req_bypass = 2'b01;
        drive(); req_valid = '0;
        wait_idle();
        drive(); req_valid = 2'b10; req_bypass = 2'b00; req_data = {$urandom, $urandom};
        @(negedge clk);
        drive(); req_valid = '0;
        @(negedge clk);
        @(negedge clk); chk("rstmid.busy_wait", bsy[0], 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.rsp_valid", d_rv[0], 0);
        chk("rstmid.accum_in", ain[0], 0);
        chk("rstmid.busy", bsy[0], 0);
        chk("rstmid.busy3", bsy[1], 0);
        @(negedge clk);
        drive(); rst = 1'b0; req_valid = 2'b11;
        @(negedge clk);
        chk("rstmid.grant0", d_ready[0], 2'b01);
        chk("rstmid.grant0_3", d_ready[1], 2'b01);
        for (int c = 0; c < 1500; c++) begin
            drive();
            req_valid  = 2'($urandom);
            req_data   = {$urandom, $urandom};
            req_bypass = 2'($urandom);
            rsp_ready  = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
